// File: rtl/ysyx_22050710_data_sram_resp_pkg.sv
// Shared core constants for the data-SRAM response stage.
// Holds the default bus geometry, the base of the mapped data region,
// and the response FSM state encoding used by every stage that
// talks to the data SRAM.
package ysyx_22050710_data_sram_resp_pkg;

    localparam int unsigned DEF_SRAM_ADDR_WD  = 32;
    localparam int unsigned DEF_SRAM_WMASK_WD = 8;
    localparam int unsigned DEF_SRAM_DATA_WD  = 64;
    localparam int unsigned DEF_DEPTH         = 1024;
    localparam logic [31:0] DEF_BASE_ADDR     = 32'h8000_0000;

    // Upper bound on extra wait states (counter is 3 bits wide).
    localparam int unsigned MAX_WAIT_CYCLES   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_22050710_data_sram_resp_if.sv
// Request/response bus between a requester (master) and the data-SRAM
// response stage (slave).
//   i_addr/i_ren/i_wen/i_wmask/i_wdata : request, master -> slave
//   o_ready                            : slave accepts a request this cycle
//   o_resp_valid/o_rdata/o_err         : one-cycle response, slave -> master
interface ysyx_22050710_data_sram_resp_if
    import ysyx_22050710_data_sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_WD  = DEF_SRAM_ADDR_WD,
    parameter int unsigned WMASK_WD = DEF_SRAM_WMASK_WD,
    parameter int unsigned DATA_WD  = DEF_SRAM_DATA_WD
);

    logic [ADDR_WD-1:0]  i_addr;
    logic                i_ren;
    logic                i_wen;
    logic [WMASK_WD-1:0] i_wmask;
    logic [DATA_WD-1:0]  i_wdata;
    logic                o_ready;
    logic                o_resp_valid;
    logic [DATA_WD-1:0]  o_rdata;
    logic                o_err;

    modport master (
        output i_addr, i_ren, i_wen, i_wmask, i_wdata,
        input  o_ready, o_resp_valid, o_rdata, o_err
    );

    modport slave (
        input  i_addr, i_ren, i_wen, i_wmask, i_wdata,
        output o_ready, o_resp_valid, o_rdata, o_err
    );

endinterface

// File: rtl/ysyx_22050710_sram_array.sv
// Data storage: DEPTH words of DATA_WD bits, byte-enable synchronous
// write, synchronous read, no reset.
//   i_clk   : clock
//   i_addr  : word index shared by read and write
//   i_we    : write enable, bytes selected by i_wmask
//   i_re    : read enable; o_rdata holds its value until the next read
//   o_rdata : word as it was before a same-edge write
module ysyx_22050710_sram_array #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_WD  = 10,
    parameter int unsigned DATA_WD  = 64,
    parameter int unsigned WMASK_WD = 8
)(
    input  logic                i_clk,
    input  logic [ADDR_WD-1:0]  i_addr,
    input  logic                i_we,
    input  logic [WMASK_WD-1:0] i_wmask,
    input  logic [DATA_WD-1:0]  i_wdata,
    input  logic                i_re,
    output logic [DATA_WD-1:0]  o_rdata
);

    localparam int unsigned LANE_WD = DATA_WD / WMASK_WD;

    logic [DATA_WD-1:0] mem [DEPTH];

    // Non-blocking read and write on the same edge give read-before-write.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            o_rdata <= mem[i_addr];
        end
        for (int unsigned k = 0; k < WMASK_WD; k++) begin
            if (i_we && i_wmask[k]) begin
                mem[i_addr][k*LANE_WD +: LANE_WD] <= i_wdata[k*LANE_WD +: LANE_WD];
            end
        end
    end

endmodule

// File: rtl/ysyx_22050710_data_sram_resp.sv
// Data-SRAM response stage. Accepts one read and/or write request while
// idle, commits writes at the acceptance edge, then answers with a single
// response pulse 1+WAIT_CYCLES cycles later.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : request in, o_ready / o_resp_valid / o_rdata / o_err out
module ysyx_22050710_data_sram_resp
    import ysyx_22050710_data_sram_resp_pkg::*;
#(
    parameter int unsigned               SRAM_ADDR_WD  = DEF_SRAM_ADDR_WD,
    parameter int unsigned               SRAM_WMASK_WD = DEF_SRAM_WMASK_WD,
    parameter int unsigned               SRAM_DATA_WD  = DEF_SRAM_DATA_WD,
    parameter int unsigned               DEPTH         = DEF_DEPTH,
    parameter logic [SRAM_ADDR_WD-1:0]   BASE_ADDR     = DEF_BASE_ADDR,
    parameter int unsigned               WAIT_CYCLES   = 0
)(
    input  logic                          i_clk,
    input  logic                          i_rst,
    ysyx_22050710_data_sram_resp_if.slave bus
);

    localparam int unsigned             IDX_WD    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]              WAIT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);
    localparam logic [SRAM_ADDR_WD:0]   SPAN      = (SRAM_ADDR_WD + 1)'(8 * DEPTH);

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    rd_q;
    logic                    err_q;
    logic                    accept;
    logic                    req;
    logic                    in_range;
    logic [SRAM_ADDR_WD:0]   offset;
    logic [IDX_WD-1:0]       word_idx;
    logic [SRAM_DATA_WD-1:0] sram_rdata;

    // One extra bit keeps the subtraction from wrapping: an address below
    // BASE_ADDR yields a huge offset and so fails the single compare.
    assign offset   = {1'b0, bus.i_addr} - {1'b0, BASE_ADDR};
    assign in_range = (offset < SPAN);
    assign word_idx = offset[IDX_WD+2:3];
    assign req      = bus.i_ren | bus.i_wen;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_q  <= bus.i_ren;
                err_q <= ~in_range;
            end
        end
    end

    // Storage is touched only at acceptance; the read register then holds
    // the pre-write word through any wait states.
    ysyx_22050710_sram_array #(
        .DEPTH    (DEPTH),
        .ADDR_WD  (IDX_WD),
        .DATA_WD  (SRAM_DATA_WD),
        .WMASK_WD (SRAM_WMASK_WD)
    ) u_sram_array (
        .i_clk   (i_clk),
        .i_addr  (word_idx),
        .i_we    (accept && bus.i_wen && in_range && !i_rst),
        .i_wmask (bus.i_wmask),
        .i_wdata (bus.i_wdata),
        .i_re    (accept && bus.i_ren && in_range && !i_rst),
        .o_rdata (sram_rdata)
    );

    assign bus.o_ready      = (state_q == ST_IDLE);
    assign bus.o_resp_valid = (state_q == ST_RESP);
    assign bus.o_err        = (state_q == ST_RESP) && err_q;
    assign bus.o_rdata      = ((state_q == ST_RESP) && rd_q && !err_q) ? sram_rdata : '0;

endmodule

// File: doc/ysyx_22050710_data_sram_resp.md
YSYX_22050710_DATA_SRAM_RESP -- requirements
Module: ysyx_22050710_data_sram_resp

Interface
REQ-001 SHALL have parameters: SRAM_ADDR_WD=32 (request address width); SRAM_WMASK_WD=8 (byte-enable width); SRAM_DATA_WD=64 (data width); DEPTH=1024 (storage words); BASE_ADDR=32'h8000_0000 (first mapped byte); WAIT_CYCLES=0 (extra read/write wait states, 0..7).
REQ-002 SHALL have one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst, in, 1, sync active-high reset.
- i_addr, in, SRAM_ADDR_WD, byte address.
- i_ren, in, 1, read request.
- i_wen, in, 1, write request.
- i_wmask, in, SRAM_WMASK_WD, byte enables for write.
- i_wdata, in, SRAM_DATA_WD, write data (pre-aligned lanes).
- o_ready, out, 1, request accepted this cycle when high.
- o_resp_valid, out, 1, one-cycle response pulse.
- o_rdata, out, SRAM_DATA_WD, read data, valid with o_resp_valid for reads.
- o_err, out, 1, out-of-range access, valid with o_resp_valid.

Function
REQ-004 Request = i_ren|i_wen; accepted on a rising edge where request && o_ready.
REQ-005 FSM states IDLE, WAIT, RESP; o_ready=1 only in IDLE.
REQ-006 IDLE + accepted request: WAIT_CYCLES==0 -> RESP next cycle; else -> WAIT with counter loaded to WAIT_CYCLES-1.
REQ-007 WAIT: counter decrements each cycle; at 0 -> RESP.
REQ-008 RESP: o_resp_valid=1 for exactly one cycle, then IDLE; total latency acceptance-to-response = 1+WAIT_CYCLES cycles.
REQ-009 Word index = (i_addr-BASE_ADDR)>>3; bits [2:0] ignored; in range iff BASE_ADDR <= i_addr < BASE_ADDR+8*DEPTH (compare in 33-bit arithmetic, no wrap).
REQ-010 Request fields latched at acceptance; inputs ignored while o_ready=0.
REQ-011 In-range write commits at the acceptance edge, only bytes with i_wmask[k]=1 updated; i_wmask=0 -> no change, still responds.
REQ-012 In-range read returns word contents as of the acceptance edge, before any same-request write (read-before-write when i_ren&&i_wen).
REQ-013 Out-of-range: no storage update, o_rdata=0, o_err=1 in RESP cycle.
REQ-014 Write-only response: o_rdata=0, o_err per REQ-013.
REQ-015 o_rdata, o_err held 0 whenever o_resp_valid=0.
REQ-016 Back-to-back: request in IDLE cycle following RESP accepted normally; with WAIT_CYCLES==0 sustained throughput is one request per 2 cycles.

Reset
REQ-017 i_rst: state IDLE, counter 0, latched request cleared, o_resp_valid=0, o_rdata=0, o_err=0; o_ready=1 the cycle after reset deasserts.
REQ-018 Reset in WAIT/RESP aborts the transaction: no response pulse; writes already committed stay committed.
REQ-019 Storage contents not reset.

Structure
REQ-020 BASE_ADDR default, data/mask widths and FSM state encodings SHALL live in the shared core constants header used by all stages.
REQ-021 Storage SHALL be sub-module ysyx_22050710_sram_array: DEPTH x SRAM_DATA_WD, byte-enable synchronous write, synchronous read, no reset.
REQ-022 All flops SHALL use the codebase Reg primitive or equivalent sync-reset flops.

Verification
REQ-023 WAIT_CYCLES=0: write addr 0x8000_0010 data 0x1122_3344_5566_7788 mask 0xFF, then read same -> resp 1 cycle after each acceptance, rdata 0x1122334455667788, err=0.
REQ-024 Partial write mask 0x0F data 0xAAAA_AAAA_BBBB_BBBB over word 0x1122334455667788, read -> 0x11223344BBBBBBBB.
REQ-025 ren&&wen same request, old word 0, new 0xFF..FF mask 0xFF -> rdata 0; following read -> 0xFFFFFFFFFFFFFFFF.
REQ-026 Read 0x7FFF_FFF8 and 0x8000_2000 (DEPTH=1024) -> err=1, rdata=0; write there leaves all words unchanged.
REQ-027 WAIT_CYCLES=3: read -> o_ready low 4 cycles, resp exactly 4 cycles after acceptance; assert i_rst during WAIT -> no resp, o_ready=1 next cycle.
